// File: rtl/temp_bcd_sched_pkg.sv
// Shared types and constants for the temperature-to-BCD display sequencer.
package temp_pkg;

  localparam int TEMP_W        = 7;
  localparam int DIGIT_W       = 4;
  localparam int BCD_DIGIT_MAX = 9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SPI_WAIT,
    CONV,
    CONV_WAIT,
    LATCH
  } state_t;

  // True when a converter digit is a legal decimal digit.
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/temp_bcd_sched_timer.sv
// Free-running sample period counter; tick marks the last cycle of each period.
module sched_timer #(
  parameter int PERIOD = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // Count 0..PERIOD-1 while enabled; hold at zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/temp_bcd_sched.sv
// Sequencer: periodic SPI temperature read, clamp, BCD conversion, display latch.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | waiting for a period tick
// REQ       | pulse spi_req, arm wait counter
// SPI_WAIT  | waiting for spi_done or timeout
// CONV      | pulse bcd_start, arm wait counter
// CONV_WAIT | waiting for bcd_done or timeout
// LATCH     | validate captured digits, update display
module temp_bcd_sched
  import temp_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int WAIT_TIMEOUT  = 4096,
  parameter int TEMP_MAX      = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               spi_req,
  input  logic               spi_done,
  input  logic [TEMP_W-1:0]  spi_data,
  output logic               bcd_start,
  output logic [TEMP_W-1:0]  bcd_bin,
  input  logic               bcd_done,
  input  logic [DIGIT_W-1:0] bcd_tens,
  input  logic [DIGIT_W-1:0] bcd_ones,
  output logic [DIGIT_W-1:0] disp_tens,
  output logic [DIGIT_W-1:0] disp_ones,
  output logic               disp_valid,
  output logic               overrange,
  output logic               err,
  output logic               busy
);

  localparam int WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WW-1:0]     WLAST = WW'(WAIT_TIMEOUT - 1);
  localparam logic [TEMP_W-1:0] TMAX  = TEMP_W'(TEMP_MAX);

  state_t state, state_nxt;
  logic [WW-1:0]      wait_cnt;
  logic [DIGIT_W-1:0] cap_tens, cap_ones;
  logic tick, wait_clr, wait_to, cap_spi, cap_bcd, time_out, latch_ok, latch_bad;
  logic pend_valid;

  sched_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and handshake strobes; a done pulse beats a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    spi_req   = 1'b0;
    bcd_start = 1'b0;
    busy      = (state != IDLE);
    wait_clr  = 1'b0;
    wait_to   = (wait_cnt == WLAST);
    cap_spi   = 1'b0;
    cap_bcd   = 1'b0;
    time_out  = 1'b0;
    latch_ok  = 1'b0;
    latch_bad = 1'b0;
    case (state)
      IDLE: if (tick && enable) state_nxt = REQ;
      REQ: begin
        spi_req   = 1'b1;
        wait_clr  = 1'b1;
        state_nxt = SPI_WAIT;
      end
      SPI_WAIT: begin
        if (spi_done) begin
          cap_spi   = 1'b1;
          state_nxt = CONV;
        end else if (wait_to) begin
          time_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      CONV: begin
        bcd_start = 1'b1;
        wait_clr  = 1'b1;
        state_nxt = CONV_WAIT;
      end
      CONV_WAIT: begin
        if (bcd_done) begin
          cap_bcd   = 1'b1;
          state_nxt = LATCH;
        end else if (wait_to) begin
          time_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      LATCH: begin
        if (digit_ok(cap_tens) && digit_ok(cap_ones)) latch_ok = 1'b1;
        else                                          latch_bad = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter: armed in REQ/CONV, advances while a handshake is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (wait_clr) begin
      wait_cnt <= '0;
    end else if ((state == SPI_WAIT || state == CONV_WAIT) && !wait_to) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Sample clamp, digit capture, display latch, sticky error and the delayed valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_bin    <= '0;
      overrange  <= 1'b0;
      cap_tens   <= '0;
      cap_ones   <= '0;
      disp_tens  <= '0;
      disp_ones  <= '0;
      err        <= 1'b0;
      pend_valid <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      if (cap_spi) begin
        if (spi_data > TMAX) begin
          bcd_bin   <= TMAX;
          overrange <= 1'b1;
        end else begin
          bcd_bin   <= spi_data;
          overrange <= 1'b0;
        end
      end
      if (cap_bcd) begin
        cap_tens <= bcd_tens;
        cap_ones <= bcd_ones;
      end
      if (latch_ok) begin
        disp_tens <= cap_tens;
        disp_ones <= cap_ones;
        err       <= 1'b0;
      end else if (time_out || latch_bad) begin
        err <= 1'b1;
      end
      pend_valid <= latch_ok;
      disp_valid <= pend_valid;
    end
  end

endmodule

// File: tb/tb_temp_bcd_sched.sv
// Randomized scoreboard bench for temp_bcd_sched.
module tb_temp_bcd_sched;

  localparam int P = 16;
  localparam int T = 8;
  localparam int TMAX = 99;
  localparam int GOOD = 0, SPI_TO = 1, CONV_TO = 2, BADDIG = 3;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic spi_done = 1'b0, bcd_done = 1'b0;
  logic [6:0] spi_data = '0;
  logic [3:0] bcd_tens = '0, bcd_ones = '0;
  logic spi_req, bcd_start, disp_valid, overrange, err, busy;
  logic [6:0] bcd_bin;
  logic [3:0] disp_tens, disp_ones;

  int cyc = 0, total = 0, bad = 0, prev_req = 0;
  int m_tens = 0, m_ones = 0, m_err = 0;

  typedef struct {
    int tens;
    int ones;
    int at;
  } exp_t;
  exp_t sb[$];

  temp_bcd_sched #(.SAMPLE_PERIOD(P), .WAIT_TIMEOUT(T), .TEMP_MAX(TMAX)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spi_req(spi_req), .spi_done(spi_done), .spi_data(spi_data),
    .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .disp_tens(disp_tens), .disp_ones(disp_ones), .disp_valid(disp_valid),
    .overrange(overrange), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_state_after(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), m_err);
    check({tag, "_disp_tens"}, int'(disp_tens), m_tens);
    check({tag, "_disp_ones"}, int'(disp_ones), m_ones);
  endtask

  // Monitor: every disp_valid pulse must match the oldest expected latch.
  initial begin
    forever begin
      @(negedge clk);
      if (disp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("disp_valid_unexpected", int'(disp_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("disp_valid_cycle", cyc, e.at);
          check("disp_valid_tens", int'(disp_tens), e.tens);
          check("disp_valid_ones", int'(disp_ones), e.ones);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_req(output int rc, output bit ok);
    int i;
    ok = 1'b0;
    rc = 0;
    i = 0;
    while (!ok && i < 3 * P) begin
      step();
      i++;
      if (spi_req === 1'b1) begin
        rc = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) check("spi_req_timeout", int'(spi_req), 1);
  endtask

  // One transaction seen from the peers' side; expectations come from the clamp/digit rules.
  task automatic run_txn(input int mode, input int data, input int k, input int l, input bit drop_en);
    int r, d, bin, n;
    bit ok;
    wait_req(r, ok);
    if (!ok) return;
    check("req_period", r, prev_req + P);
    prev_req = r;
    n = (mode == SPI_TO) ? T : k;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) begin
        check("spi_req_pulse", int'(spi_req), 0);
        if (drop_en) enable = 1'b0;
      end
    end
    if (mode == SPI_TO) begin
      check("spi_to_busy_hold", int'(busy), 1);
      step();
      m_err = 1;
      check_state_after("spi_to");
      return;
    end
    d = cyc;
    spi_done = 1'b1;
    spi_data = 7'(data);
    step();
    spi_done = 1'b0;
    spi_data = 7'($urandom);
    bin = (data > TMAX) ? TMAX : data;
    check("bcd_start", int'(bcd_start), 1);
    check("bcd_bin", int'(bcd_bin), bin);
    check("overrange", int'(overrange), int'(data > TMAX));
    n = (mode == CONV_TO) ? T : l;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) check("bcd_start_pulse", int'(bcd_start), 0);
    end
    if (mode == CONV_TO) begin
      check("conv_to_busy_hold", int'(busy), 1);
      step();
      m_err = 1;
      check_state_after("conv_to");
      return;
    end
    check("bcd_bin_hold", int'(bcd_bin), bin);
    bcd_done = 1'b1;
    bcd_tens = 4'(bin / 10);
    bcd_ones = 4'(bin % 10);
    if (mode == BADDIG) begin
      if ($urandom_range(0, 1) == 1) bcd_tens = 4'($urandom_range(10, 15));
      else                           bcd_ones = 4'($urandom_range(10, 15));
    end
    step();
    bcd_done = 1'b0;
    bcd_tens = 4'($urandom);
    bcd_ones = 4'($urandom);
    if (mode == GOOD) begin
      sb.push_back('{tens: bin / 10, ones: bin % 10, at: d + 2 + l + 2});
      m_tens = bin / 10;
      m_ones = bin % 10;
      m_err = 0;
    end else begin
      m_err = 1;
    end
    step();
    check_state_after(mode == GOOD ? "latch" : "bad_digit");
  endtask

  initial begin
    int r, cnt, mode, k;
    bit ok;

    repeat (3) step();
    check("rst_spi_req", int'(spi_req), 0);
    check("rst_bcd_start", int'(bcd_start), 0);
    check("rst_bcd_bin", int'(bcd_bin), 0);
    check("rst_disp", int'({disp_tens, disp_ones}), 0);
    check("rst_flags", int'({disp_valid, overrange, err, busy}), 0);
    reset = 1'b0;
    enable = 1'b1;
    prev_req = cyc;

    // Abandon a transaction mid conversion; the late bcd_done must be ignored.
    wait_req(r, ok);
    check("req_after_reset", r, prev_req + P);
    repeat (2) step();
    spi_done = 1'b1;
    spi_data = 7'd33;
    step();
    spi_done = 1'b0;
    check("pre_reset_bin", int'(bcd_bin), 33);
    step();
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    prev_req = cyc;
    bcd_done = 1'b1;
    bcd_tens = 4'd3;
    bcd_ones = 4'd3;
    step();
    bcd_done = 1'b0;
    check("midrst_bin", int'(bcd_bin), 0);
    check("midrst_overrange", int'(overrange), 0);
    check_state_after("midrst");
    repeat (3) step();
    check("midrst_still_idle", int'(busy), 0);

    run_txn(GOOD, 57, 2, 4, 1'b0);
    run_txn(GOOD, 120, 3, 2, 1'b0);
    run_txn(SPI_TO, 0, 1, 1, 1'b0);
    run_txn(GOOD, 42, 1, 1, 1'b0);
    run_txn(BADDIG, 64, 2, 3, 1'b0);
    run_txn(GOOD, 99, T, 4, 1'b0);
    run_txn(GOOD, 100, 4, T, 1'b0);
    run_txn(CONV_TO, 18, 2, 1, 1'b0);
    run_txn(GOOD, 0, 1, 1, 1'b0);

    // Drop enable right after a request: the sample still completes, then no more requests.
    run_txn(GOOD, 73, 2, 3, 1'b1);
    cnt = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      if (spi_req === 1'b1) cnt++;
    end
    check("no_req_while_disabled", cnt, 0);
    enable = 1'b1;
    prev_req = cyc;

    for (int i = 0; i < 20; i++) begin
      mode = $urandom_range(0, 9);
      if (mode <= 5) mode = GOOD;
      else if (mode == 6) mode = SPI_TO;
      else if (mode == 7) mode = CONV_TO;
      else mode = BADDIG;
      k = (mode == CONV_TO) ? $urandom_range(1, 5) : $urandom_range(1, T);
      run_txn(mode, $urandom_range(0, 127), k, $urandom_range(1, 4), 1'b0);
    end

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
